// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter with a small byte FIFO in front of it.
// Bit timing comes from a per-bit cycle counter running on i_clk.
//
//   state | meaning
//   ------+------------------------------------------------------
//   IDLE  | line high, waiting for a queued byte
//   START | start bit (low) for CLKS_PER_BIT cycles
//   DATA  | eight data bits, LSB first, CLKS_PER_BIT cycles each
//   STOP  | stop bit (high); chains straight into START if queued
module uart_tx_fifo #(
    parameter int INPUT_CLOCK = 27000000,
    parameter int BAUD_RATE   = 9600,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [7:0]                    i_data,
    input  logic                          i_valid,
    output logic                          o_ready,
    output logic                          o_tx,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

    localparam int CLKS_PER_BIT = INPUT_CLOCK / BAUD_RATE;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int CW           = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]    COUNT_FULL = CW'(FIFO_DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [7:0]       mem_d [FIFO_DEPTH];

    logic push;
    logic pop;
    logic bit_end;
    logic fifo_empty;

    // Ready looks only at the registered count, so a full FIFO refuses a push
    // even on the cycle the transmitter pops.
    assign o_ready      = (count_q < COUNT_FULL);
    assign push         = i_valid && o_ready;
    assign fifo_empty   = (count_q == '0);
    assign bit_end      = (cnt_q == CNT_LAST);

    assign o_tx         = tx_q;
    assign o_busy       = (state_q != IDLE) || !fifo_empty;
    assign o_fifo_count = count_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d  = 1'b1;
                cnt_d = '0;
                bit_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end

            START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    bit_d = '0;
                    // Back-to-back frames: the next start bit begins on the
                    // edge right after the last stop cycle.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                cnt_d   = '0;
                bit_d   = '0;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;

        if (push) begin
            mem_d[wr_ptr_q] = i_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers and count decide what is valid.
    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Standalone UART transmitter: accepts bytes over a valid/ready handshake into a small FIFO, serialises each as 8N1 on o_tx.
- Timing comes from an internal per-bit cycle counter, not a divided clock; the block runs entirely on i_clk.
- It is the TX-side companion to the team's UART receive path. Host logic such as a command responder or log dumper pushes bytes without tracking line timing.

Parameters:
- INPUT_CLOCK, 27000000, i_clk frequency in Hz.
- BAUD_RATE, 9600, line rate in bit/s. CLKS_PER_BIT = INPUT_CLOCK / BAUD_RATE, truncated integer division; 2812 at defaults; must be >= 2.
- FIFO_DEPTH, 4, byte entries; power of 2, >= 2.

Ports:
- i_clk  input  1  system clock
- i_rst_n  input  1  synchronous active-low reset
- i_data  input  8  byte to send; sampled only on a handshake cycle
- i_valid  input  1  producer has a byte
- o_ready  output  1  FIFO can accept; high when count < FIFO_DEPTH
- o_tx  output  1  serial line, idles high
- o_busy  output  1  high if FSM not IDLE or FIFO non-empty
- o_fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes queued, excluding the byte in flight

Behaviour:
- Interface decision: one clock (i_clk); reset is synchronous and active-low (i_rst_n).
- Reset (sampled low on a rising edge):
  - o_tx=1, o_ready=1, o_busy=0, o_fifo_count=0, FSM=IDLE, bit counter and cycle counter = 0, FIFO pointers cleared.
  - Applies mid-frame: the line returns high on that edge and the partial frame is abandoned, not resumed.
- Handshake:
  - A byte is accepted on any rising edge with i_valid=1 and o_ready=1.
  - i_valid with o_ready=0 is ignored: no state change, no overwrite.
  - o_ready is derived from the registered count only. When full, a same-cycle pop does not allow a push.
- FIFO: circular buffer, read/write pointers wrap modulo FIFO_DEPTH. A simultaneous push and pop leaves the count unchanged, and both operations take effect.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: o_tx=1. If count > 0: pop head into an 8-bit shift register, drive o_tx=0, go to START. With an empty FIFO, the start bit appears on the edge after the accepting edge (1-cycle latency).
  - START: o_tx=0 held CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: o_tx = shift[0], LSB first, each bit held exactly CLKS_PER_BIT cycles. Shift right after each bit. After bit index 7 completes, go to STOP.
  - STOP: o_tx=1 for CLKS_PER_BIT cycles. On its last cycle:
    - FIFO non-empty: pop and go directly to START, so the next start bit follows with zero idle cycles.
    - FIFO empty: go to IDLE.
- Frame length is exactly 10*CLKS_PER_BIT cycles. The cycle counter runs 0..CLKS_PER_BIT-1 and wraps at each bit boundary.
- o_tx is registered and glitch-free.
- o_busy deasserts on the edge at which STOP ends with an empty FIFO.
- Undefined FSM encodings return to IDLE with o_tx=1.

Test Plan:
Bench overrides INPUT_CLOCK=1600 and BAUD_RATE=100, giving CLKS_PER_BIT=16.
1. Reset: hold i_rst_n=0 for 5 cycles with i_valid=1, i_data=0x55 -> o_tx=1, o_ready=1, o_busy=0, o_fifo_count=0 throughout; nothing transmitted after release until a new push.
2. Single byte: push 0xA5 once -> o_tx falls 1 cycle after accept. Line then carries 0 (start), 1,0,1,0,0,1,0,1 (data), 1 (stop), each 16 cycles. o_busy falls exactly 160 cycles after o_tx fell.
3. Burst and back-pressure: hold i_valid=1 with 0x00, 0xFF, 0x55, 0xAA, 0x3C, 0x81 on consecutive cycles -> first five accepted (first popped immediately, then count reaches 4). o_ready=0 holds 0x81 until the 0x00 frame's stop bit ends. Six frames are contiguous, with stop-to-start gap = 0 cycles, and arrive in order.
4. Full, ignored push: fill FIFO while a frame is in flight, then present 0x77 with i_valid=1 for 10 cycles -> o_fifo_count stays 4, 0x77 is never transmitted, queued bytes are unchanged.
5. Reset mid-frame: send 0x0F, assert i_rst_n=0 for 1 cycle at frame cycle 50 -> o_tx=1 from the reset edge, o_fifo_count=0, o_busy=0, no further line transitions; a subsequent push of 0xC3 produces a clean full frame.
